// File: rtl/cnt_pkg.sv
// cnt_pkg: shared definitions for the down-counting timer.
//   cnt_state_t   : FSM state encoding (ST_IDLE, ST_RUN, ST_HOLD)
//   CNT_WIDTH_DEF : default width of count, load value and reload register
package cnt_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } cnt_state_t;

  localparam int CNT_WIDTH_DEF = 16;

endpackage

// File: rtl/cnt_prescaler.sv
// cnt_prescaler: divides clk into a decrement tick every PRESC enabled clocks.
// Ports:
//   clk   in  clock, rising edge
//   rst   in  synchronous active-high reset, zeroes the prescaler count
//   clr   in  synchronous clear, zeroes the prescaler count
//   en    in  advance the prescaler this clock; the count holds while low
//   tick  out high in the enabled clock where the count sits at PRESC-1
module cnt_prescaler #(
  parameter int PRESC = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  // PRESC=1 still needs a 1-bit register; it simply never leaves zero.
  localparam int              PW   = (PRESC > 1) ? $clog2(PRESC) : 1;
  localparam logic [PW-1:0]   LAST = PW'(PRESC - 1);

  logic [PW-1:0] presc_cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      presc_cnt <= '0;
    end else if (en) begin
      presc_cnt <= (presc_cnt == LAST) ? '0 : presc_cnt + PW'(1);
    end
  end

  assign tick = en && (presc_cnt == LAST);

endmodule

// File: rtl/cnt_down_timer.sv
// cnt_down_timer: loadable down-counting timer with single-cycle done pulse.
// Ports:
//   clk         in   clock, rising edge
//   rst         in   synchronous active-high reset
//   load_valid  in   load_value is valid
//   load_ready  out  a load is accepted (IDLE only)
//   load_value  in   start value (WIDTH)
//   start       in   1-cycle request to begin counting, honoured in IDLE
//   pause       in   level; freezes count and prescaler while held
//   abort       in   1-cycle cancel, returns to IDLE with count=0
//   count       out  remaining count (WIDTH)
//   busy        out  state != IDLE
//   done        out  1-cycle pulse when the count reaches zero
// Build option: define CNT_DOWN_AUTO_RELOAD_EN to reload count from
// reload_reg on reaching zero and keep running (periodic mode).
//
// state   | meaning
// --------+---------------------------------------------------------
// ST_IDLE | stopped; accepts loads and start
// ST_RUN  | counting down once per prescaler tick
// ST_HOLD | paused; count and prescaler frozen while pause stays high
module cnt_down_timer
  import cnt_pkg::*;
#(
  parameter int WIDTH = CNT_WIDTH_DEF,
  parameter int PRESC = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_value,
  input  logic             start,
  input  logic             pause,
  input  logic             abort,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done
);

  cnt_state_t       state, state_nx;
  logic [WIDTH-1:0] reload_reg, reload_nx;
  logic [WIDTH-1:0] count_nx, start_val;
  logic             done_nx;
  logic             active;
  logic             tick;

  // The edge that raises pause still lets a pending tick complete; from then
  // on the timer stays frozen until pause drops, and the release edge counts.
  assign active = (state == ST_RUN) || ((state == ST_HOLD) && !pause);

  cnt_prescaler #(
    .PRESC (PRESC)
  ) u_presc (
    .clk  (clk),
    .rst  (rst),
    .clr  ((state == ST_IDLE) || abort),
    .en   (active),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      count      <= '0;
      reload_reg <= '0;
      done       <= 1'b0;
    end else begin
      state      <= state_nx;
      count      <= count_nx;
      reload_reg <= reload_nx;
      done       <= done_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    count_nx  = count;
    reload_nx = reload_reg;
    done_nx   = 1'b0;
    start_val = count;

    if (abort) begin
      state_nx = ST_IDLE;
      count_nx = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (load_valid) begin
            count_nx  = load_value;
            reload_nx = load_value;
            start_val = load_value;
          end
          // A zero start value finishes immediately without entering RUN.
          if (start) begin
            if (start_val == '0) begin
              done_nx = 1'b1;
            end else begin
              state_nx = ST_RUN;
            end
          end
        end
        ST_RUN, ST_HOLD: begin
          if (active) begin
            state_nx = pause ? ST_HOLD : ST_RUN;
            if (tick) begin
              if (count <= WIDTH'(1)) begin
                done_nx = 1'b1;
`ifdef CNT_DOWN_AUTO_RELOAD_EN
                if (reload_reg != '0) begin
                  count_nx = reload_reg;
                end else begin
                  count_nx = '0;
                  state_nx = ST_IDLE;
                end
`else
                count_nx = '0;
                state_nx = ST_IDLE;
`endif
              end else begin
                count_nx = count - WIDTH'(1);
              end
            end
          end
        end
        default: begin
          state_nx = ST_IDLE;
        end
      endcase
    end
  end

  assign load_ready = (state == ST_IDLE);
  assign busy       = (state != ST_IDLE);

endmodule
